dmem_access: RTL and testbench

//  Data-memory block sitting beside the MEM stage. It consumes the stage's address and memWriteData,
//  and returns memReadData for the writeback mux.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_lane_align.sv | 71 +++++++
 rtl/dmem_access.sv | 130 +++++++++++++
 tb/tb_dmem_access.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory block: funct3 access encodings, FSM states, wait-counter width.
// Imported by dmem_access and dmem_lane_align.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough for WAIT_STATES up to 15.
    localparam int CNT_W = 4;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        return (((f3 == F3_H) || (f3 == F3_HU)) && lane[0]) || ((f3 == F3_W) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: extracts and sign/zero-extends load data, and merges store bytes
// into the addressed word so the RAM only ever sees whole-word read-modify-write.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int WORD_BITWIDTH = 32
) (
    input  logic [WORD_BITWIDTH-1:0] i_rd_word,
    input  logic [WORD_BITWIDTH-1:0] i_wr_data,
    input  logic [2:0]               i_funct3,
    input  logic [1:0]               i_lane,
    output logic [WORD_BITWIDTH-1:0] o_load_data,
    output logic [WORD_BITWIDTH-1:0] o_store_word,
    output logic                     o_store_en
);

    logic [4:0]               w_shift_b;
    logic [4:0]               w_shift_h;
    logic [7:0]               w_byte;
    logic [15:0]              w_half;
    logic [WORD_BITWIDTH-1:0] w_mask;
    logic [WORD_BITWIDTH-1:0] w_lane_data;

    assign w_shift_b = {i_lane, 3'b000};
    assign w_shift_h = {i_lane[1], 4'b0000};
    assign w_byte    = 8'(i_rd_word >> w_shift_b);
    assign w_half    = 16'(i_rd_word >> w_shift_h);

    always_comb begin
        o_load_data = i_rd_word;
        case (i_funct3)
            F3_B:    o_load_data = {{(WORD_BITWIDTH-8){w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {{(WORD_BITWIDTH-8){1'b0}}, w_byte};
            F3_H:    o_load_data = {{(WORD_BITWIDTH-16){w_half[15]}}, w_half};
            F3_HU:   o_load_data = {{(WORD_BITWIDTH-16){1'b0}}, w_half};
            default: o_load_data = i_rd_word;
        endcase
    end

    // Invalid store sizes produce an all-zero mask and drop the write enable.
    always_comb begin
        w_mask      = '0;
        w_lane_data = '0;
        o_store_en  = 1'b0;
        case (i_funct3)
            F3_B: begin
                w_mask      = WORD_BITWIDTH'(8'hFF) << w_shift_b;
                w_lane_data = WORD_BITWIDTH'(i_wr_data[7:0]) << w_shift_b;
                o_store_en  = 1'b1;
            end
            F3_H: begin
                w_mask      = WORD_BITWIDTH'(16'hFFFF) << w_shift_h;
                w_lane_data = WORD_BITWIDTH'(i_wr_data[15:0]) << w_shift_h;
                o_store_en  = 1'b1;
            end
            F3_W: begin
                w_mask      = '1;
                w_lane_data = i_wr_data;
                o_store_en  = 1'b1;
            end
            default: begin
                w_mask      = '0;
                w_lane_data = '0;
                o_store_en  = 1'b0;
            end
        endcase
    end

    assign o_store_word = (i_rd_word & ~w_mask) | (w_lane_data & w_mask);

endmodule

// File: rtl/dmem_access.sv
// Wait-stated data memory beside the MEM stage: byte/half/word loads and stores, stall held for
// WAIT_STATES+2 cycles per access. Optional misalignment trap under macro DMEM_MISALIGN_CHECK_EN.
module dmem_access
    import dmem_pkg::*;
#(
    parameter int WORD_BITWIDTH = 32,
    parameter int ADDR_BITWIDTH = 10,
    parameter int WAIT_STATES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memRead,
    input  logic                     memWrite,
    input  logic [2:0]               funct3,
    input  logic [WORD_BITWIDTH-1:0] address,
    input  logic [WORD_BITWIDTH-1:0] memWriteData,
    output logic [WORD_BITWIDTH-1:0] memReadData,
    output logic                     stall,
    output logic                     misaligned
);

    localparam int DEPTH = 2 ** ADDR_BITWIDTH;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [ADDR_BITWIDTH-1:0] r_idx;
    logic [1:0]               r_lane;
    logic [WORD_BITWIDTH-1:0] r_wdata;
    logic [2:0]               r_f3;
    logic                     r_is_store;
    logic [WORD_BITWIDTH-1:0] r_rdata;
    logic [WORD_BITWIDTH-1:0] r_mem [DEPTH];

    logic                     w_req;
    logic                     w_fire;
    logic                     w_mis;
    logic [WORD_BITWIDTH-1:0] w_rd_word;
    logic [WORD_BITWIDTH-1:0] w_load_data;
    logic [WORD_BITWIDTH-1:0] w_store_word;
    logic                     w_store_en;
    logic                     w_unused_addr;

    assign w_req         = memRead | memWrite;
    assign w_fire        = (r_state == BUSY) && (r_cnt == '0);
    assign w_rd_word     = r_mem[r_idx];
    assign w_unused_addr = ^address[WORD_BITWIDTH-1:ADDR_BITWIDTH+2];

    dmem_lane_align #(
        .WORD_BITWIDTH(WORD_BITWIDTH)
    ) u_lane_align (
        .i_rd_word   (w_rd_word),
        .i_wr_data   (r_wdata),
        .i_funct3    (r_f3),
        .i_lane      (r_lane),
        .o_load_data (w_load_data),
        .o_store_word(w_store_word),
        .o_store_en  (w_store_en)
    );

    always_comb begin
        stall = 1'b0;
        case (r_state)
            IDLE:    stall = w_req;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx      <= address[ADDR_BITWIDTH+1:2];
                        r_lane     <= address[1:0];
                        r_wdata    <= memWriteData;
                        r_f3       <= funct3;
                        r_is_store <= memWrite;
                        r_cnt      <= CNT_W'(WAIT_STATES);
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        if (!r_is_store) begin
                            r_rdata <= w_mis ? '0 : w_load_data;
                        end
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset wins over a completing store so an interrupted access never lands.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && r_is_store && w_store_en && !w_mis) begin
            r_mem[r_idx] <= w_store_word;
        end
    end

    assign memReadData = r_rdata;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic r_mis;

    assign w_mis = is_misaligned(r_f3, r_lane);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mis <= 1'b0;
        end else begin
            r_mis <= w_fire && w_mis;
        end
    end

    assign misaligned = r_mis;
`else
    assign w_mis      = 1'b0;
    assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access.sv
// Randomised scoreboard bench for dmem_access: a byte-array reference model predicts each access,
// a negedge monitor checks stall length, memReadData and misaligned when each access completes.
module tb_dmem_access;
    import dmem_pkg::*;

    localparam int WS    = 2;
    localparam int AB    = 10;
    localparam int DEPTH = 1 << AB;
    localparam int NB    = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        stall;
    logic        misaligned;

    always #5 clk = ~clk;

    dmem_access #(
        .WORD_BITWIDTH(32),
        .ADDR_BITWIDTH(AB),
        .WAIT_STATES  (WS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .funct3      (funct3),
        .address     (address),
        .memWriteData(memWriteData),
        .memReadData (memReadData),
        .stall       (stall),
        .misaligned  (misaligned)
    );

    typedef struct packed {
        logic        is_load;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mdl [NB];
    logic [31:0] last_rd = 32'h0;
    int          run = 0;
    bit          aborted = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit mdl_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((f3 == F3_H || f3 == F3_HU) && (addr % 2 != 0)) return 1'b1;
        if (f3 == F3_W && (addr % 4 != 0)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] addr);
        int          a = int'(addr % NB);
        int          h = a - (a % 2);
        int          w = a - (a % 4);
        logic [31:0] word = {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
        logic [15:0] half = {mdl[h+1], mdl[h]};
        logic [7:0]  b = mdl[a];
        case (f3)
            3'b000:  return (b >= 8'h80) ? 32'hFFFFFF00 + 32'(b) : 32'(b);
            3'b100:  return 32'(b);
            3'b001:  return (half >= 16'h8000) ? 32'hFFFF0000 + 32'(half) : 32'(half);
            3'b101:  return 32'(half);
            default: return word;
        endcase
    endfunction

    task automatic mdl_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int a = int'(addr % NB);
        int h = a - (a % 2);
        int w = a - (a % 4);
        case (f3)
            3'b000: mdl[a] = wd[7:0];
            3'b001: begin mdl[h] = wd[7:0]; mdl[h+1] = wd[15:8]; end
            3'b010: for (int k = 0; k < 4; k++) mdl[w+k] = 8'(wd >> (8*k));
            default: ;
        endcase
    endtask

    // Drives one access from IDLE at posedge+1, returns at posedge+1 after DONE with the request dropped.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit use_lit, input logic [31:0] lit);
        exp_t e;
        int   n;
        bit   mis = mdl_mis(f3, addr);
        e.is_load = !wr;
        e.mis     = mis;
        if (wr) begin
            if (!mis) mdl_store(f3, addr, wd);
        end else begin
            last_rd = mis ? 32'h0 : mdl_load(f3, addr);
            if (use_lit) last_rd = lit;
        end
        e.data = last_rd;
        sb.push_back(e);
        memRead = rd; memWrite = wr; funct3 = f3; address = addr; memWriteData = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 64);
        if (n >= 64) begin
            errors++;
            checks++;
            $display("FAIL access_timeout: stall still %b after %0d cycles, required 0", stall, n);
        end
        @(posedge clk);
        #1;
        memRead = 1'b0;
        memWrite = 1'b0;
    endtask

    // Monitor: a falling stall marks DONE for a normal access, or the end of an aborted one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && stall) aborted = 1'b1;
            if (stall) begin
                run++;
                if (rst) aborted = 1'b1;
            end else if (run > 0) begin
                if (!aborted) begin
                    if (sb.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_done: got completion, required none pending");
                    end else begin
                        e = sb.pop_front();
                        check32("stall_len", 32'(run), 32'(WS + 2));
                        check32(e.is_load ? "load_data" : "store_keeps_rdata", memReadData, e.data);
                        check32("misaligned", {31'h0, misaligned}, {31'h0, e.mis});
                    end
                end
                run = 0;
                aborted = 1'b0;
            end
        end
    end

    initial begin
        int gap;
        logic [2:0]  f3;
        logic [31:0] a;
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b0; address = 32'h0; memWriteData = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_stall", {31'h0, stall}, 32'h0);
        check32("reset_rdata", memReadData, 32'h0);
        check32("reset_misaligned", {31'h0, misaligned}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++) access(1'b0, 1'b1, F3_W, 32'(i * 4), $urandom, 1'b0, 32'h0);

        access(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        access(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        access(1'b1, 1'b0, F3_B,  32'h13, 32'h0, 1'b1, 32'hFFFFFFDE);
        access(1'b1, 1'b0, F3_BU, 32'h13, 32'h0, 1'b1, 32'h000000DE);
        access(1'b1, 1'b0, F3_H,  32'h10, 32'h0, 1'b1, 32'hFFFFBEEF);
        access(1'b1, 1'b0, F3_HU, 32'h12, 32'h0, 1'b1, 32'h0000DEAD);
        access(1'b0, 1'b1, F3_B, 32'h11, 32'hABCDEF55, 1'b0, 32'h0);
        access(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1, 32'hDEAD55EF);
        access(1'b0, 1'b1, F3_H, 32'h12, 32'h99991234, 1'b0, 32'h0);
        access(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1, 32'h123455EF);
        access(1'b0, 1'b1, F3_W, 32'h4, 32'hA5A5A5A5, 1'b0, 32'h0);
        access(1'b1, 1'b0, F3_W, 32'h4 + 32'(4 * DEPTH), 32'h0, 1'b1, 32'hA5A5A5A5);
        access(1'b1, 1'b1, F3_W, 32'h8, 32'h0F0F0F0F, 1'b0, 32'h0);
        access(1'b1, 1'b0, F3_W, 32'h8, 32'h0, 1'b1, 32'h0F0F0F0F);

        // Reset lands in the second BUSY cycle of a store to word 8.
        memWrite = 1'b1; funct3 = F3_W; address = 32'h20; memWriteData = 32'h1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1; memWrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check32("abort_stall", {31'h0, stall}, 32'h0);
        check32("abort_rdata", memReadData, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        last_rd = 32'h0;
        access(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b0, 32'h0);

`ifdef DMEM_MISALIGN_CHECK_EN
        access(1'b1, 1'b0, F3_W, 32'h11, 32'h0, 1'b1, 32'h0);
        access(1'b0, 1'b1, F3_H, 32'h13, 32'h0000BBBB, 1'b0, 32'h0);
        access(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1, 32'h123455EF);
`else
        access(1'b1, 1'b0, F3_W, 32'h11, 32'h0, 1'b1, 32'h123455EF);
        access(1'b0, 1'b1, F3_H, 32'h13, 32'h0000BBBB, 1'b0, 32'h0);
        access(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1, 32'hBBBB55EF);
`endif

        for (int i = 0; i < 300; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = 32'($urandom_range(0, 63)) | ($urandom << (AB + 2));
            gap = $urandom_range(0, 3);
            case (gap)
                0, 1:    access(1'b1, 1'b0, f3, a, $urandom, 1'b0, 32'h0);
                2:       access(1'b0, 1'b1, f3, a, $urandom, 1'b0, 32'h0);
                default: access(1'b1, 1'b1, f3, a, $urandom, 1'b0, 32'h0);
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (5) @(negedge clk);
        check32("pending_at_end", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
